// File: rtl/mem_bus.sv
// mem_bus: CPU memory-map decoder with internal WRAM/HRAM/IE, an external
// pass-through port and the OAM DMA engine that owns the bus while running.
module mem_bus #(
    parameter int WRAM_BYTES = 8192,
    parameter int DMA_TICKS  = 4,
    parameter int DMA_LEN    = 160
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [15:0] i_cpu_rd_addr,
    output logic [7:0]  o_cpu_rd_data,
    input  logic        i_cpu_wr_en,
    input  logic [15:0] i_cpu_wr_addr,
    input  logic [7:0]  i_cpu_wr_data,
    output logic [15:0] o_ext_rd_addr,
    input  logic [7:0]  i_ext_rd_data,
    output logic        o_ext_wr_en,
    output logic [15:0] o_ext_wr_addr,
    output logic [7:0]  o_ext_wr_data,
    output logic        o_dma_active
);
    localparam int WA = $clog2(WRAM_BYTES);
    localparam int TW = $clog2(DMA_TICKS);

    typedef enum logic [2:0] {T_EXT, T_WRAM, T_UNUSED, T_DMAREG, T_HRAM, T_IE} target_e;
    typedef enum logic [1:0] {S_IDLE, S_START, S_XFER} state_e;

    // Address map shared by the read and write ports.
    function automatic target_e decode(input logic [15:0] a);
        if (a < 16'hC000)       return T_EXT;
        else if (a < 16'hFE00)  return T_WRAM;
        else if (a < 16'hFEA0)  return T_EXT;
        else if (a < 16'hFF00)  return T_UNUSED;
        else if (a == 16'hFF46) return T_DMAREG;
        else if (a < 16'hFF80)  return T_EXT;
        else if (a == 16'hFFFF) return T_IE;
        else                    return T_HRAM;
    endfunction

    // WRAM offset; anything at or above E000 is treated as the echo window.
    function automatic logic [WA-1:0] wram_index(input logic [15:0] a);
        return WA'((a >= 16'hE000) ? (a - 16'hE000) : (a - 16'hC000));
    endfunction

    logic [7:0] wram_mem [WRAM_BYTES];
    logic [7:0] hram_mem [128];

    state_e          state_q, state_d;
    logic [TW-1:0]   tick_q, tick_d;
    logic [7:0]      idx_q, idx_d;
    logic [7:0]      dma_reg_q, dma_reg_d;
    logic [7:0]      ie_q, ie_d;
    logic [7:0]      rd_data_q, rd_data_d;
    logic            ext_wr_en_q, ext_wr_en_d;
    logic [15:0]     ext_wr_addr_q, ext_wr_addr_d;
    logic [7:0]      ext_wr_data_q, ext_wr_data_d;

    logic            dma_active, dma_rd, dma_trig, wram_we, hram_we;
    logic [15:0]     dma_src;
    logic [7:0]      dma_data;
    target_e         rd_tgt, wr_tgt;

    assign dma_active    = (state_q != S_IDLE);
    assign dma_rd        = (state_q == S_XFER) && (tick_q == '0);
    assign dma_src       = {dma_reg_q, idx_q};
    assign rd_tgt        = decode(i_cpu_rd_addr);
    assign wr_tgt        = decode(i_cpu_wr_addr);
    assign o_ext_rd_addr = dma_rd ? dma_src : i_cpu_rd_addr;
    assign o_cpu_rd_data = rd_data_q;
    assign o_ext_wr_en   = ext_wr_en_q;
    assign o_ext_wr_addr = ext_wr_addr_q;
    assign o_ext_wr_data = ext_wr_data_q;
    assign o_dma_active  = dma_active;

    // CPU read mux; the bus is locked out below FF80 while DMA runs.
    always_comb begin
        rd_data_d = 8'hFF;
        if (!dma_active || i_cpu_rd_addr >= 16'hFF80) begin
            case (rd_tgt)
                T_EXT:    rd_data_d = i_ext_rd_data;
                T_WRAM:   rd_data_d = wram_mem[wram_index(i_cpu_rd_addr)];
                T_DMAREG: rd_data_d = dma_reg_q;
                T_HRAM:   rd_data_d = hram_mem[i_cpu_rd_addr[6:0]];
                T_IE:     rd_data_d = ie_q;
                default:  rd_data_d = 8'hFF;
            endcase
        end
    end

    // DMA source byte: C0-FF pages come from WRAM (echo above E0), the rest from EXT.
    always_comb begin
        dma_data = i_ext_rd_data;
        if (dma_reg_q >= 8'hC0) dma_data = wram_mem[wram_index(dma_src)];
    end

    // Write decode; a DMA byte is staged at sub-tick 0 so its pulse lands in sub-tick 1.
    always_comb begin
        wram_we       = 1'b0;
        hram_we       = 1'b0;
        dma_trig      = 1'b0;
        ie_d          = ie_q;
        dma_reg_d     = dma_reg_q;
        ext_wr_en_d   = 1'b0;
        ext_wr_addr_d = ext_wr_addr_q;
        ext_wr_data_d = ext_wr_data_q;
        if (i_cpu_wr_en) begin
            case (wr_tgt)
                T_WRAM:   wram_we = !dma_active;
                T_HRAM:   hram_we = 1'b1;
                T_IE:     ie_d = i_cpu_wr_data;
                T_DMAREG: begin
                    dma_reg_d = i_cpu_wr_data;
                    dma_trig  = 1'b1;
                end
                T_EXT: begin
                    if (!dma_active) begin
                        ext_wr_en_d   = 1'b1;
                        ext_wr_addr_d = i_cpu_wr_addr;
                        ext_wr_data_d = i_cpu_wr_data;
                    end
                end
                default: ;
            endcase
        end
        if (dma_rd && !dma_trig) begin
            ext_wr_en_d   = 1'b1;
            ext_wr_addr_d = 16'hFE00 + {8'h00, idx_q};
            ext_wr_data_d = dma_data;
        end
    end

    // DMA next-state: a FF46 write always (re)starts at START with idx 0.
    always_comb begin
        state_d = state_q;
        tick_d  = tick_q;
        idx_d   = idx_q;
        if (dma_trig) begin
            state_d = S_START;
            tick_d  = '0;
            idx_d   = 8'd0;
        end else begin
            case (state_q)
                S_START: begin
                    tick_d = tick_q + TW'(1);
                    if (tick_q == TW'(DMA_TICKS - 1)) begin
                        state_d = S_XFER;
                        tick_d  = '0;
                    end
                end
                S_XFER: begin
                    tick_d = tick_q + TW'(1);
                    if (tick_q == TW'(DMA_TICKS - 1)) begin
                        tick_d = '0;
                        if (idx_q == 8'(DMA_LEN - 1)) begin
                            state_d = S_IDLE;
                            idx_d   = 8'd0;
                        end else begin
                            idx_d = idx_q + 8'd1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Control and output registers with asynchronous reset.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q       <= S_IDLE;
            tick_q        <= '0;
            idx_q         <= 8'd0;
            dma_reg_q     <= 8'h00;
            ie_q          <= 8'h00;
            rd_data_q     <= 8'h00;
            ext_wr_en_q   <= 1'b0;
            ext_wr_addr_q <= 16'h0000;
            ext_wr_data_q <= 8'h00;
        end else begin
            state_q       <= state_d;
            tick_q        <= tick_d;
            idx_q         <= idx_d;
            dma_reg_q     <= dma_reg_d;
            ie_q          <= ie_d;
            rd_data_q     <= rd_data_d;
            ext_wr_en_q   <= ext_wr_en_d;
            ext_wr_addr_q <= ext_wr_addr_d;
            ext_wr_data_q <= ext_wr_data_d;
        end
    end

    // RAM arrays are not reset; reads sample the old contents (read-before-write).
    always_ff @(posedge i_clk) begin
        if (wram_we) wram_mem[wram_index(i_cpu_wr_addr)] <= i_cpu_wr_data;
        if (hram_we) hram_mem[i_cpu_wr_addr[6:0]] <= i_cpu_wr_data;
    end
endmodule

// File: tb/tb_mem_bus.sv
// tb_mem_bus: directed checks of decode, read/write paths and OAM DMA.
module tb_mem_bus;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] cpu_rd_addr = 16'h0000;
    logic [7:0]  cpu_rd_data;
    logic        cpu_wr_en = 1'b0;
    logic [15:0] cpu_wr_addr = 16'h0000;
    logic [7:0]  cpu_wr_data = 8'h00;
    logic [15:0] ext_rd_addr;
    logic [7:0]  ext_rd_data;
    logic        ext_wr_en;
    logic [15:0] ext_wr_addr;
    logic [7:0]  ext_wr_data;
    logic        dma_active;

    int tests = 0;
    int failed = 0;
    int active_cnt = 0;
    logic [15:0] wa_q [$];
    logic [15:0] wd_q [$];
    logic [15:0] exp_a_q [$];
    logic [15:0] exp_d_q [$];

    mem_bus dut (
        .i_clk(clk), .i_rst(rst),
        .i_cpu_rd_addr(cpu_rd_addr), .o_cpu_rd_data(cpu_rd_data),
        .i_cpu_wr_en(cpu_wr_en), .i_cpu_wr_addr(cpu_wr_addr), .i_cpu_wr_data(cpu_wr_data),
        .o_ext_rd_addr(ext_rd_addr), .i_ext_rd_data(ext_rd_data),
        .o_ext_wr_en(ext_wr_en), .o_ext_wr_addr(ext_wr_addr), .o_ext_wr_data(ext_wr_data),
        .o_dma_active(dma_active)
    );

    // External memory model: fixed byte at 0150, otherwise low address byte ^ 5C.
    assign ext_rd_data = (ext_rd_addr == 16'h0150) ? 8'h3C : (ext_rd_addr[7:0] ^ 8'h5C);

    always #5 clk = ~clk;

    // Monitor: log every external write pulse and count DMA-active cycles.
    always @(negedge clk) begin
        if (ext_wr_en === 1'b1) begin
            wa_q.push_back(ext_wr_addr);
            wd_q.push_back({8'h00, ext_wr_data});
        end
        if (dma_active === 1'b1) active_cnt++;
    end

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cpu_write(input logic [15:0] a, input logic [7:0] d);
        cpu_wr_en = 1'b1;
        cpu_wr_addr = a;
        cpu_wr_data = d;
        @(negedge clk);
        cpu_wr_en = 1'b0;
    endtask

    task automatic cpu_read(input logic [15:0] a, output logic [7:0] d);
        cpu_rd_addr = a;
        @(negedge clk);
        d = cpu_rd_data;
    endtask

    task automatic wait_dma_done(input string tag);
        for (int i = 0; i < 3000 && dma_active === 1'b1; i++) @(negedge clk);
        check(tag, {15'd0, dma_active}, 16'd0);
    endtask

    logic [7:0] rd;
    int base_w, base_a, cnt;

    initial begin
        // Reset state
        #3;
        check("rst_rd_data", {8'h00, cpu_rd_data}, 16'h0000);
        check("rst_wr_en", {15'd0, ext_wr_en}, 16'd0);
        check("rst_wr_addr", ext_wr_addr, 16'h0000);
        check("rst_wr_data", {8'h00, ext_wr_data}, 16'h0000);
        check("rst_dma_active", {15'd0, dma_active}, 16'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        cpu_read(16'hFF46, rd); check("rst_dma_reg", {8'h00, rd}, 16'h0000);
        cpu_read(16'hFFFF, rd); check("rst_ie", {8'h00, rd}, 16'h0000);

        // WRAM and echo
        cpu_write(16'hC123, 8'h5A);
        cpu_read(16'hE123, rd); check("echo_rd", {8'h00, rd}, 16'h005A);
        cpu_read(16'hC123, rd); check("wram_rd", {8'h00, rd}, 16'h005A);

        // Read-before-write on the same internal address
        cpu_write(16'hC200, 8'h11);
        cpu_rd_addr = 16'hC200;
        cpu_write(16'hC200, 8'h22);
        check("rbw_old", {8'h00, cpu_rd_data}, 16'h0011);
        @(negedge clk);
        check("rbw_new", {8'h00, cpu_rd_data}, 16'h0022);

        // EXT pass-through
        cpu_rd_addr = 16'h0150;
        #1 check("ext_rd_addr", ext_rd_addr, 16'h0150);
        @(negedge clk);
        check("ext_rd_data", {8'h00, cpu_rd_data}, 16'h003C);
        base_w = wa_q.size();
        cpu_write(16'h8000, 8'h77);
        repeat (3) @(negedge clk);
        check("ext_wr_count", 16'(wa_q.size() - base_w), 16'd1);
        if (wa_q.size() > base_w) begin
            check("ext_wr_addr", wa_q[base_w], 16'h8000);
            check("ext_wr_data", wd_q[base_w], 16'h0077);
        end

        // Unusable region and IE
        cpu_read(16'hFEA5, rd); check("unusable_rd", {8'h00, rd}, 16'h00FF);
        cpu_write(16'hFFFF, 8'h1F);
        cpu_read(16'hFFFF, rd); check("ie_rd", {8'h00, rd}, 16'h001F);
        base_w = wa_q.size();
        cpu_write(16'hFEA5, 8'h33);
        repeat (3) @(negedge clk);
        check("unusable_no_wr", 16'(wa_q.size() - base_w), 16'd0);

        // DMA from WRAM with CPU lockout checks while it runs
        for (int i = 0; i < 160; i++) cpu_write(16'hC000 + 16'(i), 8'(i) ^ 8'hA5);
        base_w = wa_q.size();
        base_a = active_cnt;
        cpu_write(16'hFF46, 8'hC0);
        check("dma_active_set", {15'd0, dma_active}, 16'd1);
        cpu_read(16'hC000, rd); check("lock_rd", {8'h00, rd}, 16'h00FF);
        cpu_write(16'h8000, 8'h99);
        cpu_write(16'hC000, 8'h00);
        cpu_write(16'hFF90, 8'h12);
        cpu_read(16'hFF90, rd); check("lock_hram", {8'h00, rd}, 16'h0012);
        wait_dma_done("dma1_timeout");
        check("dma1_active_clks", 16'(active_cnt - base_a), 16'd644);
        check("dma1_count", 16'(wa_q.size() - base_w), 16'd160);
        exp_a_q.delete(); exp_d_q.delete();
        for (int i = 0; i < 160; i++) begin
            exp_a_q.push_back(16'hFE00 + 16'(i));
            exp_d_q.push_back({8'h00, 8'(i) ^ 8'hA5});
        end
        if (wa_q.size() - base_w == 160) begin
            for (int i = 0; i < 160; i++) begin
                check($sformatf("dma1_addr[%0d]", i), wa_q[base_w + i], exp_a_q[i]);
                check($sformatf("dma1_data[%0d]", i), wd_q[base_w + i], exp_d_q[i]);
            end
        end
        cpu_read(16'hFF46, rd); check("dma_reg_rd", {8'h00, rd}, 16'h00C0);
        cpu_read(16'hC000, rd); check("lock_wr_dropped", {8'h00, rd}, 16'h00A5);

        // Re-trigger after 50 bytes with a new source page
        base_w = wa_q.size();
        cpu_write(16'hFF46, 8'hC0);
        cnt = 0;
        do begin
            @(negedge clk); #1; cnt++;
        end while (wa_q.size() - base_w < 50 && cnt < 2000);
        check("retrig_wait", 16'(wa_q.size() - base_w), 16'd50);
        repeat (2) @(negedge clk);
        cpu_write(16'hFF46, 8'h80);
        wait_dma_done("dma2_timeout");
        check("dma2_count", 16'(wa_q.size() - base_w), 16'd210);
        exp_a_q.delete(); exp_d_q.delete();
        for (int i = 0; i < 50; i++) begin
            exp_a_q.push_back(16'hFE00 + 16'(i));
            exp_d_q.push_back({8'h00, 8'(i) ^ 8'hA5});
        end
        for (int i = 0; i < 160; i++) begin
            exp_a_q.push_back(16'hFE00 + 16'(i));
            exp_d_q.push_back({8'h00, 8'(i) ^ 8'h5C});
        end
        if (wa_q.size() - base_w == 210) begin
            for (int i = 0; i < 210; i++) begin
                check($sformatf("dma2_addr[%0d]", i), wa_q[base_w + i], exp_a_q[i]);
                check($sformatf("dma2_data[%0d]", i), wd_q[base_w + i], exp_d_q[i]);
            end
        end

        // Reset in the middle of a transfer
        cpu_write(16'hFF46, 8'hC0);
        repeat (100) @(negedge clk);
        #1 rst = 1'b1;
        #1;
        check("rst_mid_active", {15'd0, dma_active}, 16'd0);
        check("rst_mid_wr_en", {15'd0, ext_wr_en}, 16'd0);
        base_w = wa_q.size();
        @(negedge clk);
        rst = 1'b0;
        repeat (700) @(negedge clk);
        check("rst_mid_no_wr", 16'(wa_q.size() - base_w), 16'd0);
        check("rst_mid_idle", {15'd0, dma_active}, 16'd0);
        cpu_read(16'hFFFF, rd); check("rst_mid_ie", {8'h00, rd}, 16'h0000);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
